// File: rtl/axi_pkg.sv
// Shared AXI constants, encodings and FSM state type for the SRAM slave.
package axi_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_RESP
  } state_e;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word memory with per-byte write enables and a registered read port.
module sram_1rw_be #(
  parameter int    ADDR_BITS = 14,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rd,
  input  logic                 clr,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          q
);

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  // Byte-lane writes; contents are never cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read register: cleared on demand, otherwise holds until the next read.
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else if (rd) q <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a byte-enabled word SRAM.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int    ADDR_BITS = 14,
  parameter int    RD_DELAY  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Delay counter is loaded with one less than the wait count; zero delay skips RD_WAIT.
  localparam int DLY_M1 = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;

  state_e               state, state_nxt;
  logic                 prio_wr;
  logic [ADDR_BITS-1:0] idx, idx_nxt;
  logic [LEN_W-1:0]     len, beat, dly;
  burst_e               burst;
  logic                 err;
  logic                 last_beat, rsvd;
  logic                 mem_rd, mem_clr;
  logic [3:0]           mem_we;
  logic                 unused_ok;

  assign last_beat = (beat == len);
  assign rsvd      = (burst == BURST_RSVD);
  assign idx_nxt   = (burst == BURST_FIXED) ? idx : idx + ADDR_BITS'(1);

  // Sideband fields and aliased address bits carry no meaning here.
  assign unused_ok = ^{araddr[31:ADDR_BITS+2], araddr[1:0], arlen[7:4], arsize, arlock,
                       arcache, arprot, awaddr[31:ADDR_BITS+2], awaddr[1:0], awlen[7:4],
                       awsize, awlock, awcache, awprot, wid};

  sram_1rw_be #(.ADDR_BITS(ADDR_BITS), .INIT_FILE(INIT_FILE)) u_mem (
    .clk   (clk),
    .rd    (mem_rd),
    .clr   (mem_clr),
    .we    (mem_we),
    .addr  (idx),
    .wdata (wdata),
    .q     (rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, handshake outputs, response codes and memory strobes.
  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    bvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = RESP_OKAY;
    bresp     = RESP_OKAY;
    mem_rd    = 1'b0;
    mem_clr   = ~resetn;
    mem_we    = 4'b0000;
    case (state)
      IDLE: begin
        arready = resetn & ~(awvalid & prio_wr);
        awready = resetn & ~(arvalid & ~prio_wr);
        if (arvalid && arready)      state_nxt = RD_ISSUE;
        else if (awvalid && awready) state_nxt = WR_DATA;
      end
      RD_ISSUE: begin
        mem_rd = 1'b1;
        if (rsvd) mem_clr = 1'b1;
        state_nxt = (RD_DELAY == 0) ? RD_RESP : RD_WAIT;
      end
      RD_WAIT: begin
        if (dly == '0) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        rresp  = rsvd ? RESP_SLVERR : RESP_OKAY;
        if (rready) state_nxt = last_beat ? IDLE : RD_ISSUE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we = rsvd ? 4'b0000 : wstrb;
          if (last_beat) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = (rsvd || err) ? RESP_SLVERR : RESP_OKAY;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, arbitration priority, beat/delay counters and error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio_wr <= 1'b1;
      rid     <= '0;
      bid     <= '0;
      idx     <= '0;
      len     <= '0;
      beat    <= '0;
      dly     <= '0;
      burst   <= BURST_INCR;
      err     <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        prio_wr <= ~prio_wr;
        rid     <= arid;
        idx     <= araddr[ADDR_BITS+1:2];
        len     <= arlen[3:0];
        burst   <= burst_e'(arburst);
        beat    <= '0;
      end else if (awvalid && awready) begin
        prio_wr <= ~prio_wr;
        bid     <= awid;
        idx     <= awaddr[ADDR_BITS+1:2];
        len     <= awlen[3:0];
        burst   <= burst_e'(awburst);
        beat    <= '0;
        err     <= 1'b0;
      end
      if (state == RD_ISSUE) dly <= 4'(DLY_M1);
      if (state == RD_WAIT && dly != '0) dly <= dly - 4'd1;
      if (state == RD_RESP && rready && !last_beat) begin
        idx  <= idx_nxt;
        beat <= beat + 4'd1;
      end
      if (state == WR_DATA && wvalid) begin
        if (wlast != last_beat) err <= 1'b1;
        idx  <= idx_nxt;
        beat <= beat + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: zero-delay instance plus a RD_DELAY=3 instance.
module tb_axi_sram_slave;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, d_resetn;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  logic [3:0]  d_arid, d_rid;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [1:0]  d_arburst, d_rresp;
  logic        d_arvalid, d_arready, d_rvalid, d_rready, d_rlast;
  logic        d_unused_awready, d_unused_wready, d_unused_bvalid;
  logic [3:0]  d_unused_bid;
  logic [1:0]  d_unused_bresp;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rresp_b [16];
  logic        rlast_b [16];
  logic [3:0]  got_rid, got_bid;
  logic [1:0]  got_bresp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_slave #(.ADDR_BITS(14), .RD_DELAY(0)) u_dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(arburst),
    .arlock(2'd0), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(awburst),
    .awlock(2'd0), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
    .wid(4'd0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_slave #(.ADDR_BITS(14), .RD_DELAY(3)) u_dly (
    .clk(clk), .resetn(d_resetn),
    .arid(d_arid), .araddr(d_araddr), .arlen(d_arlen), .arsize(3'd2), .arburst(d_arburst),
    .arlock(2'd0), .arcache(4'd0), .arprot(3'd0), .arvalid(d_arvalid), .arready(d_arready),
    .rid(d_rid), .rdata(d_rdata), .rresp(d_rresp), .rlast(d_rlast), .rvalid(d_rvalid),
    .rready(d_rready),
    .awid(4'd0), .awaddr(32'd0), .awlen(8'd0), .awsize(3'd2), .awburst(2'd1),
    .awlock(2'd0), .awcache(4'd0), .awprot(3'd0), .awvalid(1'b0), .awready(d_unused_awready),
    .wid(4'd0), .wdata(32'd0), .wstrb(4'd0), .wlast(1'b0), .wvalid(1'b0),
    .wready(d_unused_wready),
    .bid(d_unused_bid), .bresp(d_unused_bresp), .bvalid(d_unused_bvalid), .bready(1'b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int wlast_at);
    int n;
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 40) begin step(); n++; end
    check("aw_ready", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
    check("w_ready_first", 32'(wready), 32'd1);
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == wlast_at);
      #1;
      n = 0;
      while (!wready && n < 40) begin step(); n++; end
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", 32'(bvalid), 32'd1);
    got_bresp = bresp; got_bid = bid;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    int n, tref;
    logic [31:0] held;
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 40) begin step(); n++; end
    check("ar_ready", 32'(arready), 32'd1);
    tref = cyc;
    step();
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      rready = (b == stall_beat) ? 1'b0 : 1'b1;
      n = 0;
      while (!rvalid && n < 40) begin step(); n++; end
      check("r_latency", 32'(cyc - tref), 32'd2);
      if (b == stall_beat) begin
        held = rdata;
        for (int s = 0; s < stall_cyc; s++) begin
          step();
          check("r_hold_valid", 32'(rvalid), 32'd1);
          check("r_hold_data", rdata, held);
        end
        rready = 1'b1;
        #1;
      end
      rbuf[b] = rdata; rresp_b[b] = rresp; rlast_b[b] = rlast; got_rid = rid;
      tref = cyc;
      step();
    end
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int t, n;
    resetn = 1'b0; d_resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'd1; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'd1; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    d_arid = '0; d_araddr = '0; d_arlen = '0; d_arburst = 2'd1; d_arvalid = 1'b0;
    d_rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end
    repeat (3) step();
    check("rst_readies", 32'({arready, awready, wready}), 32'd0);
    check("rst_valids", 32'({rvalid, bvalid, rlast}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ids_resp", 32'({rid, bid, rresp, bresp}), 32'd0);
    resetn = 1'b1; d_resetn = 1'b1;
    #1;
    check("idle_readies", 32'({arready, awready}), 32'b11);

    // Single read of a preloaded word.
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    axi_write(4'd0, 32'h14, 0, 2'b01, 0);
    check("pre_bresp", 32'(got_bresp), 32'd0);
    wbuf[0] = 32'h0;
    axi_write(4'd0, 32'h20, 0, 2'b01, 0);
    axi_read(4'd0, 32'h14, 0, 2'b01, -1, 0);
    check("single_data", rbuf[0], 32'h12345678);
    check("single_rid", 32'(got_rid), 32'd0);
    check("single_rlast", 32'(rlast_b[0]), 32'd1);
    check("single_rresp", 32'(rresp_b[0]), 32'd0);

    // Byte-lane write merges into an existing zero word.
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0100;
    axi_write(4'd1, 32'h20, 0, 2'b01, 0);
    check("byte_bid", 32'(got_bid), 32'd1);
    check("byte_bresp", 32'(got_bresp), 32'd0);
    axi_read(4'd1, 32'h20, 0, 2'b01, -1, 0);
    check("byte_data", rbuf[0], 32'h00BB0000);

    // INCR burst with a stalled second beat.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(4'd2, 32'h100, 3, 2'b01, 3);
    axi_read(4'd2, 32'h100, 3, 2'b01, 1, 3);
    for (int i = 0; i < 4; i++) begin
      check("incr_data", rbuf[i], 32'(i + 1));
      check("incr_rlast", 32'(rlast_b[i]), 32'(i == 3));
    end
    check("incr_rid", 32'(got_rid), 32'd2);

    // FIXED bursts stay on one word.
    wbuf[0] = 32'hA; wbuf[1] = 32'hB;
    axi_write(4'd3, 32'h200, 1, 2'b00, 1);
    axi_read(4'd3, 32'h200, 0, 2'b01, -1, 0);
    check("fixed_wr_data", rbuf[0], 32'hB);
    axi_read(4'd4, 32'h14, 1, 2'b00, -1, 0);
    check("fixed_rd_b0", rbuf[0], 32'h12345678);
    check("fixed_rd_b1", rbuf[1], 32'h12345678);

    // Early wlast: both beats land, response flags the error.
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    axi_write(4'd5, 32'h300, 1, 2'b01, 0);
    check("wlast_bresp", 32'(got_bresp), 32'd2);
    check("wlast_bid", 32'(got_bid), 32'd5);
    axi_read(4'd5, 32'h300, 1, 2'b01, -1, 0);
    check("wlast_b0", rbuf[0], 32'h11);
    check("wlast_b1", rbuf[1], 32'h22);

    // Reserved burst type on both channels.
    axi_read(4'd6, 32'h14, 0, 2'b11, -1, 0);
    check("rsvd_rdata", rbuf[0], 32'h0);
    check("rsvd_rresp", 32'(rresp_b[0]), 32'd2);
    wbuf[0] = 32'hDEADBEEF;
    axi_write(4'd7, 32'h14, 0, 2'b11, 0);
    check("rsvd_bresp", 32'(got_bresp), 32'd2);
    axi_read(4'd7, 32'h14, 0, 2'b01, -1, 0);
    check("rsvd_no_write", rbuf[0], 32'h12345678);

    // Reset restores write priority; conflicting requests alternate.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    arid = 4'd8; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd9; awaddr = 32'h400; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    #1;
    check("conf1_grant", 32'({arready, awready}), 32'b01);
    wbuf[0] = 32'h55; sbuf[0] = 4'hF;
    axi_write(4'd9, 32'h400, 0, 2'b01, 0);
    awid = 4'd10; awaddr = 32'h404; awlen = 8'd0; awvalid = 1'b1;
    #1;
    check("conf2_grant", 32'({arready, awready}), 32'b10);
    axi_read(4'd8, 32'h100, 3, 2'b01, -1, 0);
    for (int i = 0; i < 4; i++) check("after_rst_data", rbuf[i], 32'(i + 1));
    wbuf[0] = 32'h66;
    axi_write(4'd10, 32'h404, 0, 2'b01, 0);
    check("conf3_bid", 32'(got_bid), 32'd10);
    axi_read(4'd11, 32'h400, 1, 2'b01, -1, 0);
    check("raw_b0", rbuf[0], 32'h55);
    check("raw_b1", rbuf[1], 32'h66);

    // RD_DELAY=3 latency, then reset during the burst.
    d_arid = 4'd1; d_araddr = 32'h0; d_arlen = 8'd3; d_arburst = 2'b01; d_arvalid = 1'b1;
    d_rready = 1'b1;
    #1;
    check("d_ar_ready", 32'(d_arready), 32'd1);
    t = cyc;
    step();
    d_arvalid = 1'b0;
    n = 0;
    while (!d_rvalid && n < 40) begin step(); n++; end
    check("d_latency", 32'(cyc - t), 32'd5);
    check("d_rlast_b0", 32'(d_rlast), 32'd0);
    step();
    d_resetn = 1'b0;
    step();
    d_resetn = 1'b1;
    #1;
    check("d_rst_rvalid", 32'(d_rvalid), 32'd0);
    check("d_rst_arready", 32'(d_arready), 32'd1);
    check("d_rst_rdata", d_rdata, 32'd0);
    check("d_rst_rid", 32'(d_rid), 32'd0);
    repeat (6) step();
    check("d_rst_quiet", 32'(d_rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
